dpram_fifo_ctrl: RTL and testbench

- Synchronous FIFO controller that sits directly upstream of the 64x8 dual-port RAM and uses it as FIFO storage.
- Port A is the write port and port B is the read port.
- The block owns the pointers, occupancy count, status flags and the one-cycle read-latency alignment.
- Producers and consumers see a plain wr_en/rd_en FIFO interface and never drive RAM addresses.

---
 rtl/dpram_fifo_ctrl_if.sv | 41 ++++
 rtl/dpram_fifo_ctrl.sv | 117 +++++++++++
 tb/tb_dpram_fifo_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/dpram_fifo_ctrl_if.sv
// -----------------------------------------------------------------------------
// dpram_fifo_ctrl_if
//   Producer/consumer side of the DPRAM-backed FIFO controller.
//   master : the user of the FIFO (drives wr_en/wr_data/rd_en, sees status)
//   slave  : the FIFO controller itself
//   Signals:
//     wr_en, wr_data        write request and data
//     full, almost_full     write-side status
//     rd_en                 read request
//     rd_data, rd_valid     read data, valid one cycle after an accepted read
//     empty, almost_empty   read-side status
//     count                 occupancy 0..2**AW
//   Handshake: a write is taken on a clk edge where wr_en=1 and full=0; a read
//   is taken where rd_en=1 and empty=0. A taken read returns its word with
//   rd_valid=1 on the following cycle. Rejected requests are dropped.
// -----------------------------------------------------------------------------
interface dpram_fifo_ctrl_if #(
   parameter int DW = 8,
   parameter int AW = 6
);
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          full;
   logic          almost_full;
   logic          rd_en;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          empty;
   logic          almost_empty;
   logic [AW:0]   count;

   modport master (
      output wr_en, wr_data, rd_en,
      input  full, almost_full, rd_data, rd_valid, empty, almost_empty, count
   );

   modport slave (
      input  wr_en, wr_data, rd_en,
      output full, almost_full, rd_data, rd_valid, empty, almost_empty, count
   );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// dpram_fifo_ctrl
//   Synchronous FIFO controller using an external 64x8 dual-port RAM as
//   storage. Port A of the RAM is written, port B is read (1-cycle latency).
//   Ports:
//     clk, rst       clock; synchronous active-high reset
//     fifo           dpram_fifo_ctrl_if.slave (user-side FIFO handshake)
//     ram_addr_a/ram_data_a/ram_we_a   RAM write port drive
//     ram_addr_b/ram_data_b/ram_we_b   RAM read port drive (data/we tied 0)
//     ram_q_b        RAM port B registered read data
//     overflow, underflow   sticky error flags, only when
//                           DPRAM_FIFO_ERR_FLAGS_EN is defined
//   Optional feature macro: DPRAM_FIFO_ERR_FLAGS_EN
// -----------------------------------------------------------------------------
module dpram_fifo_ctrl #(
   parameter int DW        = 8,
   parameter int AW        = 6,
   parameter int AF_THRESH = 56,
   parameter int AE_THRESH = 8
) (
   input  logic          clk,
   input  logic          rst,
   dpram_fifo_ctrl_if.slave fifo,
   output logic [AW-1:0] ram_addr_a,
   output logic [DW-1:0] ram_data_a,
   output logic          ram_we_a,
   output logic [AW-1:0] ram_addr_b,
   output logic [DW-1:0] ram_data_b,
   output logic          ram_we_b,
   input  logic [DW-1:0] ram_q_b
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
   ,
   output logic          overflow,
   output logic          underflow
`endif
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(1 << AW);
   localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
   localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q,  count_d;
   logic          rd_valid_q;
   logic          full_s, empty_s;
   logic          wr_acc, rd_acc;

   // Flags decode only the registered count, so acceptance never depends on
   // the opposite request in the same cycle.
   assign full_s  = (count_q == DEPTH_C);
   assign empty_s = (count_q == '0);

   assign wr_acc = fifo.wr_en & ~full_s;
   assign rd_acc = fifo.rd_en & ~empty_s;

   assign fifo.full         = full_s;
   assign fifo.empty        = empty_s;
   assign fifo.almost_full  = (count_q >= AF_C);
   assign fifo.almost_empty = (count_q <= AE_C);
   assign fifo.count        = count_q;
   assign fifo.rd_valid     = rd_valid_q;
   // RAM already registers the word; rd_valid marks when it belongs to us.
   assign fifo.rd_data      = ram_q_b;

   assign ram_addr_a = wr_ptr_q;
   assign ram_data_a = fifo.wr_data;
   assign ram_we_a   = wr_acc;
   assign ram_addr_b = rd_ptr_q;
   assign ram_data_b = '0;
   assign ram_we_b   = 1'b0;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;   // wraps naturally at 2**AW
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;   // drops any read in flight at reset
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_valid_q <= rd_acc;
      end
   end

`ifdef DPRAM_FIFO_ERR_FLAGS_EN
   logic overflow_q, underflow_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (fifo.wr_en & full_s)  overflow_q  <= 1'b1;
         if (fifo.rd_en & empty_s) underflow_q <= 1'b1;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dpram_fifo_ctrl
//   Directed bench for dpram_fifo_ctrl with a behavioural 64x8 dual-port RAM
//   attached to the controller's RAM ports.
// -----------------------------------------------------------------------------
module tb_dpram_fifo_ctrl;
   localparam int DW = 8;
   localparam int AW = 6;

   logic          clk;
   logic          rst;
   logic [AW-1:0] ram_addr_a, ram_addr_b;
   logic [DW-1:0] ram_data_a, ram_data_b, ram_q_b;
   logic          ram_we_a, ram_we_b;
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
   logic          overflow, underflow;
`endif

   int n_cmp;
   int n_err;
   logic [DW-1:0] exp_q[$];

   dpram_fifo_ctrl_if #(.DW(DW), .AW(AW)) fifo_if ();

   dpram_fifo_ctrl #(.DW(DW), .AW(AW), .AF_THRESH(56), .AE_THRESH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .fifo       (fifo_if.slave),
      .ram_addr_a (ram_addr_a),
      .ram_data_a (ram_data_a),
      .ram_we_a   (ram_we_a),
      .ram_addr_b (ram_addr_b),
      .ram_data_b (ram_data_b),
      .ram_we_b   (ram_we_b),
      .ram_q_b    (ram_q_b)
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
      ,
      .overflow   (overflow),
      .underflow  (underflow)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural RAM ----------------
   logic [DW-1:0] mem [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
      if (ram_we_b) mem[ram_addr_b] <= ram_data_b;
      ram_q_b <= mem[ram_addr_b];
   end

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Apply inputs, take one clock edge, settle 1 time unit past it.
   task automatic cyc(input logic we, input logic [DW-1:0] wd, input logic re);
      fifo_if.wr_en   = we;
      fifo_if.wr_data = wd;
      fifo_if.rd_en   = re;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, '0, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      fifo_if.wr_en = 1'b0;
      fifo_if.wr_data = '0;
      fifo_if.rd_en = 1'b0;

      // Reset then idle
      idle();
      idle();
      rst = 1'b0;
      check("rst_count", 32'(fifo_if.count), 0);
      check("rst_empty", 32'(fifo_if.empty), 1);
      check("rst_aempty", 32'(fifo_if.almost_empty), 1);
      check("rst_full", 32'(fifo_if.full), 0);
      check("rst_afull", 32'(fifo_if.almost_full), 0);
      check("rst_rd_valid", 32'(fifo_if.rd_valid), 0);
      check("rst_we_a", 32'(ram_we_a), 0);
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
      check("rst_overflow", 32'(overflow), 0);
      check("rst_underflow", 32'(underflow), 0);
`endif

      // Fill with 0x01..0x40
      for (int i = 0; i < 64; i++) begin
         cyc(1'b1, 8'(i + 1), 1'b0);
         check("fill_count", 32'(fifo_if.count), 32'(i + 1));
         check("fill_afull", 32'(fifo_if.almost_full), (i + 1 >= 56) ? 1 : 0);
         check("fill_aempty", 32'(fifo_if.almost_empty), (i + 1 <= 8) ? 1 : 0);
      end
      check("fill_full", 32'(fifo_if.full), 1);
      check("fill_empty", 32'(fifo_if.empty), 0);

      // 65th write is rejected
      fifo_if.wr_en = 1'b1;
      fifo_if.wr_data = 8'hFF;
      fifo_if.rd_en = 1'b0;
      #1;
      check("ovf_we_a", 32'(ram_we_a), 0);
      @(posedge clk);
      #1;
      fifo_if.wr_en = 1'b0;
      check("ovf_count", 32'(fifo_if.count), 64);
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
      check("ovf_flag", 32'(overflow), 1);
`endif

      // Drain 64 back to back
      for (int i = 0; i < 64; i++) begin
         cyc(1'b0, '0, 1'b1);
         check("drain_valid", 32'(fifo_if.rd_valid), 1);
         check("drain_data", 32'(fifo_if.rd_data), 32'(i + 1));
         check("drain_count", 32'(fifo_if.count), 32'(63 - i));
      end
      check("drain_empty", 32'(fifo_if.empty), 1);
      cyc(1'b0, '0, 1'b1);
      check("udf_valid", 32'(fifo_if.rd_valid), 0);
      check("udf_count", 32'(fifo_if.count), 0);
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
      check("udf_flag", 32'(underflow), 1);
      check("udf_ovf_sticky", 32'(overflow), 1);
`endif
      idle();

      // Pointer wrap: write 40, read 40, write 0xA0..0xB7, read 24
      for (int i = 0; i < 40; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0);
      for (int i = 0; i < 40; i++) begin
         cyc(1'b0, '0, 1'b1);
         check("wrap_pre_data", 32'(fifo_if.rd_data), 32'(8'h30 + i));
      end
      check("wrap_wptr40", 32'(ram_addr_a), 40);
      for (int i = 0; i < 24; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0);
      check("wrap_wptr0", 32'(ram_addr_a), 0);
      check("wrap_count24", 32'(fifo_if.count), 24);
      for (int i = 0; i < 24; i++) begin
         cyc(1'b0, '0, 1'b1);
         check("wrap_valid", 32'(fifo_if.rd_valid), 1);
         check("wrap_data", 32'(fifo_if.rd_data), 32'(8'hA0 + i));
      end
      check("wrap_rptr0", 32'(ram_addr_b), 0);
      check("wrap_count0", 32'(fifo_if.count), 0);
      idle();

      // Simultaneous at count=64
      exp_q.delete();
      for (int i = 0; i < 64; i++) begin
         cyc(1'b1, 8'(8'h40 + i), 1'b0);
         exp_q.push_back(8'(8'h40 + i));
      end
      cyc(1'b1, 8'hEE, 1'b1);           // write rejected, read taken
      check("sf_count", 32'(fifo_if.count), 63);
      check("sf_valid", 32'(fifo_if.rd_valid), 1);
      check("sf_data", 32'(fifo_if.rd_data), 32'(exp_q.pop_front()));
      for (int i = 0; i < 63; i++) begin
         cyc(1'b0, '0, 1'b1);
         check("sf_drain", 32'(fifo_if.rd_data), 32'(exp_q.pop_front()));
      end
      check("sf_empty", 32'(fifo_if.empty), 1);

      // Simultaneous at count=0
      cyc(1'b1, 8'h77, 1'b1);           // write taken, read rejected
      exp_q.push_back(8'h77);
      check("se_count", 32'(fifo_if.count), 1);
      check("se_valid", 32'(fifo_if.rd_valid), 0);

      // Bring to 10, then 5 cycles of write+read
      for (int i = 0; i < 9; i++) begin
         cyc(1'b1, 8'(8'hC0 + i), 1'b0);
         exp_q.push_back(8'(8'hC0 + i));
      end
      check("sm_count10", 32'(fifo_if.count), 10);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 8'(8'hD0 + i), 1'b1);
         exp_q.push_back(8'(8'hD0 + i));
         check("sm_count", 32'(fifo_if.count), 10);
         check("sm_valid", 32'(fifo_if.rd_valid), 1);
         check("sm_data", 32'(fifo_if.rd_data), 32'(exp_q.pop_front()));
      end
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, '0, 1'b1);
         check("sm_drain", 32'(fifo_if.rd_data), 32'(exp_q.pop_front()));
      end
      check("sm_count0", 32'(fifo_if.count), 0);

      // Reset mid-operation
      for (int i = 0; i < 20; i++) cyc(1'b1, 8'(i), 1'b0);
      check("mr_count20", 32'(fifo_if.count), 20);
      rst = 1'b1;
      cyc(1'b0, '0, 1'b1);              // read request coincides with reset
      rst = 1'b0;
      check("mr_valid", 32'(fifo_if.rd_valid), 0);
      check("mr_count", 32'(fifo_if.count), 0);
      check("mr_empty", 32'(fifo_if.empty), 1);
`ifdef DPRAM_FIFO_ERR_FLAGS_EN
      check("mr_ovf_clr", 32'(overflow), 0);
      check("mr_udf_clr", 32'(underflow), 0);
`endif
      idle();
      check("mr_idle_valid", 32'(fifo_if.rd_valid), 0);
      cyc(1'b1, 8'h5A, 1'b0);
      check("mr_wr_count", 32'(fifo_if.count), 1);
      cyc(1'b0, '0, 1'b1);
      check("mr_rd_valid", 32'(fifo_if.rd_valid), 1);
      check("mr_rd_data", 32'(fifo_if.rd_data), 32'h5A);
      check("mr_rd_empty", 32'(fifo_if.empty), 1);
      idle();
      check("end_valid", 32'(fifo_if.rd_valid), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
